// File: rtl/ahblite_fm_copy_manager.sv
// ahblite_fm_copy_manager
// AHB-Lite manager that copies a block of 32-bit words from a source address
// to a destination address. Each word is one NONSEQ single read followed by
// one NONSEQ single write, with no pipelining between transfers. The block
// stretches its address and data phases on HREADY wait states, stops a job on
// the two-cycle HRESP error response, and reports BUSY / DONE / ERR to the
// local controller.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no job; waits for START
// RD_ADDR | read address phase on the bus (HTRANS=NONSEQ, HWRITE=0)
// RD_DATA | read data phase; HRDATA captured into the buffer on HREADY
// WR_ADDR | write address phase on the bus (HTRANS=NONSEQ, HWRITE=1)
// WR_DATA | write data phase; HWDATA held, word retired on HREADY
// FINISH  | job over (success or error); DONE pulses on the way to IDLE

module ahblite_fm_copy_manager #(
    parameter int LEN_WIDTH = 16
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 START,
    input  logic [31:0]          SRC_ADDR,
    input  logic [31:0]          DST_ADDR,
    input  logic [LEN_WIDTH-1:0] LEN,
    output logic                 BUSY,
    output logic                 DONE,
    output logic                 ERR,
    output logic [31:0]          HADDR,
    output logic [1:0]           HTRANS,
    output logic                 HWRITE,
    output logic [2:0]           HSIZE,
    output logic [2:0]           HBURST,
    output logic [3:0]           HPROT,
    output logic                 HMASTLOCK,
    output logic [31:0]          HWDATA,
    input  logic [31:0]          HRDATA,
    input  logic                 HREADY,
    input  logic                 HRESP
);

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_DATA = 3'd2,
        WR_ADDR = 3'd3,
        WR_DATA = 3'd4,
        FINISH  = 3'd5
    } state_t;

    state_t               state;
    logic [31:0]          src_addr;
    logic [31:0]          dst_addr;
    logic [LEN_WIDTH-1:0] word_cnt;
    logic [31:0]          data_buf;

    // Transfer attributes never vary: single word, non-burst, privileged data access, unlocked.
    assign HSIZE     = 3'b010;
    assign HBURST    = 3'b000;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;

    // Copy sequencer: every bus-facing output is registered here so that address
    // and control only ever change on a clock edge where HREADY allowed progress.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= IDLE;
            src_addr <= '0;
            dst_addr <= '0;
            word_cnt <= '0;
            data_buf <= '0;
            HADDR    <= '0;
            HTRANS   <= TRANS_IDLE;
            HWRITE   <= 1'b0;
            HWDATA   <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        ERR  <= 1'b0;
                        BUSY <= 1'b1;
                        if (LEN != '0) begin
                            src_addr <= {SRC_ADDR[31:2], 2'b00};
                            dst_addr <= {DST_ADDR[31:2], 2'b00};
                            word_cnt <= LEN;
                            HADDR    <= {SRC_ADDR[31:2], 2'b00};
                            HTRANS   <= TRANS_NONSEQ;
                            HWRITE   <= 1'b0;
                            state    <= RD_ADDR;
                        end else begin
                            state <= FINISH;
                        end
                    end
                end

                RD_ADDR: begin
                    if (HREADY) begin
                        HTRANS <= TRANS_IDLE;
                        state  <= RD_DATA;
                    end
                end

                RD_DATA: begin
                    // First error cycle arrives with HREADY low; flag it right away.
                    if (HRESP) begin
                        ERR <= 1'b1;
                    end
                    if (HREADY) begin
                        if (HRESP) begin
                            state <= FINISH;
                        end else begin
                            data_buf <= HRDATA;
                            HADDR    <= dst_addr;
                            HTRANS   <= TRANS_NONSEQ;
                            HWRITE   <= 1'b1;
                            state    <= WR_ADDR;
                        end
                    end
                end

                WR_ADDR: begin
                    if (HREADY) begin
                        HTRANS <= TRANS_IDLE;
                        HWDATA <= data_buf;
                        state  <= WR_DATA;
                    end
                end

                WR_DATA: begin
                    if (HRESP) begin
                        ERR <= 1'b1;
                    end
                    if (HREADY) begin
                        if (HRESP) begin
                            state <= FINISH;
                        end else begin
                            // Addresses wrap naturally through the 32-bit adders.
                            src_addr <= src_addr + 32'd4;
                            dst_addr <= dst_addr + 32'd4;
                            word_cnt <= word_cnt - LEN_WIDTH'(1);
                            if (word_cnt == LEN_WIDTH'(1)) begin
                                state <= FINISH;
                            end else begin
                                HADDR  <= src_addr + 32'd4;
                                HTRANS <= TRANS_NONSEQ;
                                HWRITE <= 1'b0;
                                state  <= RD_ADDR;
                            end
                        end
                    end
                end

                FINISH: begin
                    DONE  <= 1'b1;
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    HTRANS <= TRANS_IDLE;
                    BUSY   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahblite_fm_copy_manager.sv
// tb_ahblite_fm_copy_manager
// Directed bench for the AHB-Lite copy manager. A behavioural subordinate
// answers the manager's transfers (read data = address ^ 0xDEADBEEF) with
// configurable address/data wait states and an optional error on one read,
// and logs every completed read and write for comparison against
// hand-computed expectations.

module tb_ahblite_fm_copy_manager;

    logic        HCLK;
    logic        HRESETn;
    logic        START;
    logic [31:0] SRC_ADDR;
    logic [31:0] DST_ADDR;
    logic [15:0] LEN;
    logic        BUSY;
    logic        DONE;
    logic        ERR;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HMASTLOCK;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    ahblite_fm_copy_manager #(.LEN_WIDTH(16)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .START     (START),
        .SRC_ADDR  (SRC_ADDR),
        .DST_ADDR  (DST_ADDR),
        .LEN       (LEN),
        .BUSY      (BUSY),
        .DONE      (DONE),
        .ERR       (ERR),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HMASTLOCK (HMASTLOCK),
        .HWDATA    (HWDATA),
        .HRDATA    (HRDATA),
        .HREADY    (HREADY),
        .HRESP     (HRESP)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Subordinate model configuration and logs (main process edits between jobs)
    int          aw_n        = 0;
    int          dw_n        = 0;
    int          err_rd_idx  = -1;
    int          rd_started  = 0;
    int          nonseq_cnt  = 0;
    int          hold_cnt    = 0;
    int          hold_viol   = 0;
    int          done_cnt    = 0;
    logic [31:0] rd_a[$];
    logic [31:0] wr_a[$];
    logic [31:0] wr_d[$];

    bit          in_data;
    bit          addr_seen;
    bit          prev_addr_wait;
    bit          d_wr;
    bit          d_err;
    bit          a_wr;
    int          wcnt;
    int          awcnt;
    logic [31:0] d_addr;
    logic [31:0] a_addr;
    logic [31:0] d_wdata;

    // Subordinate: decides each cycle's HREADY/HRESP/HRDATA at the falling edge,
    // after retiring whatever the previous rising edge completed.
    initial begin : responder
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                in_data        = 1'b0;
                addr_seen      = 1'b0;
                prev_addr_wait = 1'b0;
                wcnt           = 0;
                awcnt          = 0;
                HREADY         = 1'b1;
                HRESP          = 1'b0;
                continue;
            end
            if (in_data) begin
                if (HREADY) in_data = 1'b0;
            end else if (addr_seen && HREADY) begin
                in_data = 1'b1;
                wcnt    = 0;
                d_addr  = a_addr;
                d_wr    = a_wr;
                d_err   = !a_wr && (rd_started == err_rd_idx);
                if (!a_wr) rd_started++;
            end
            addr_seen = (HTRANS == 2'b10);
            if (addr_seen) begin
                nonseq_cnt++;
                if (prev_addr_wait) begin
                    hold_cnt++;
                    if (HADDR !== a_addr || HWRITE !== a_wr) hold_viol++;
                end
            end
            a_addr = HADDR;
            a_wr   = HWRITE;
            HRESP  = 1'b0;
            if (in_data) begin
                if (d_wr) begin
                    if (wcnt == 0) d_wdata = HWDATA;
                    else begin
                        hold_cnt++;
                        if (HWDATA !== d_wdata) hold_viol++;
                    end
                end
                if (d_err) begin
                    HRESP  = 1'b1;
                    HREADY = (wcnt != 0);
                    wcnt++;
                end else if (wcnt < dw_n) begin
                    HREADY = 1'b0;
                    wcnt++;
                end else begin
                    HREADY = 1'b1;
                    if (d_wr) begin
                        wr_a.push_back(d_addr);
                        wr_d.push_back(HWDATA);
                    end else begin
                        HRDATA = d_addr ^ 32'hDEAD_BEEF;
                        rd_a.push_back(d_addr);
                    end
                end
            end else if (addr_seen) begin
                if (awcnt < aw_n) begin
                    HREADY = 1'b0;
                    awcnt++;
                end else begin
                    HREADY = 1'b1;
                    awcnt  = 0;
                end
            end else begin
                HREADY = 1'b1;
            end
            prev_addr_wait = !in_data && addr_seen && !HREADY;
        end
    end

    // DONE pulse counter
    initial begin : done_mon
        forever begin
            @(posedge HCLK);
            #1;
            if (DONE) done_cnt++;
        end
    end

    task automatic clear_logs();
        rd_a.delete();
        wr_a.delete();
        wr_d.delete();
        rd_started = 0;
        nonseq_cnt = 0;
        hold_cnt   = 0;
        hold_viol  = 0;
    endtask

    // Launches one job and measures START-to-DONE latency in cycles.
    task automatic run_job(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l,
                           output int lat, output logic busy1, output logic done_seen,
                           output logic busy_done, output logic err_done, output logic done_next);
        @(negedge HCLK);
        START    = 1'b1;
        SRC_ADDR = s;
        DST_ADDR = d;
        LEN      = l;
        @(negedge HCLK);
        START = 1'b0;
        busy1 = BUSY;
        lat   = 1;
        while (!DONE && lat < 400) begin
            @(negedge HCLK);
            lat++;
        end
        done_seen = DONE;
        busy_done = BUSY;
        err_done  = ERR;
        @(negedge HCLK);
        done_next = DONE;
    endtask

    int   lat;
    logic b1, dn, bd, ed, dnx;
    int   done_before;

    initial begin : main
        HRESETn  = 1'b0;
        START    = 1'b0;
        SRC_ADDR = '0;
        DST_ADDR = '0;
        LEN      = '0;
        repeat (3) @(negedge HCLK);

        check_eq("rst_htrans", 32'(HTRANS), 32'h0);
        check_eq("rst_haddr", HADDR, 32'h0);
        check_eq("rst_hwdata", HWDATA, 32'h0);
        check_eq("rst_flags", {29'd0, BUSY, DONE, ERR}, 32'h0);
        check_eq("const_ctrl", {18'd0, HSIZE, HBURST, HPROT, HMASTLOCK, HWRITE}, {18'd0, 3'b010, 3'b000, 4'b0011, 1'b0, 1'b0});
        HRESETn = 1'b1;
        repeat (2) @(negedge HCLK);

        // 1: zero-wait copy of three words
        clear_logs();
        run_job(32'h0000_1000, 32'h0000_2000, 16'd3, lat, b1, dn, bd, ed, dnx);
        check_eq("t1_done", 32'(dn), 32'h1);
        check_eq("t1_latency", 32'(lat), 32'd14);
        check_eq("t1_busy_c1", 32'(b1), 32'h1);
        check_eq("t1_busy_at_done", 32'(bd), 32'h0);
        check_eq("t1_err", 32'(ed), 32'h0);
        check_eq("t1_done_one_cycle", 32'(dnx), 32'h0);
        check_eq("t1_nrd", 32'(rd_a.size()), 32'd3);
        check_eq("t1_nwr", 32'(wr_a.size()), 32'd3);
        check_eq("t1_rd0", rd_a[0], 32'h0000_1000);
        check_eq("t1_rd1", rd_a[1], 32'h0000_1004);
        check_eq("t1_rd2", rd_a[2], 32'h0000_1008);
        check_eq("t1_wa0", wr_a[0], 32'h0000_2000);
        check_eq("t1_wa1", wr_a[1], 32'h0000_2004);
        check_eq("t1_wa2", wr_a[2], 32'h0000_2008);
        check_eq("t1_wd0", wr_d[0], 32'hDEAD_AEEF);
        check_eq("t1_wd1", wr_d[1], 32'hDEAD_AEEB);
        check_eq("t1_wd2", wr_d[2], 32'hDEAD_AEE7);

        // 2: same job with 1 address wait and 2 data waits per phase
        clear_logs();
        aw_n = 1;
        dw_n = 2;
        run_job(32'h0000_1000, 32'h0000_2000, 16'd3, lat, b1, dn, bd, ed, dnx);
        aw_n = 0;
        dw_n = 0;
        check_eq("t2_done", 32'(dn), 32'h1);
        check_eq("t2_latency", 32'(lat), 32'd32);
        check_eq("t2_hold_samples", 32'(hold_cnt), 32'd12);
        check_eq("t2_hold_viol", 32'(hold_viol), 32'd0);
        check_eq("t2_nwr", 32'(wr_a.size()), 32'd3);
        check_eq("t2_wa2", wr_a[2], 32'h0000_2008);
        check_eq("t2_wd0", wr_d[0], 32'hDEAD_AEEF);
        check_eq("t2_wd1", wr_d[1], 32'hDEAD_AEEB);
        check_eq("t2_wd2", wr_d[2], 32'hDEAD_AEE7);

        // 3: error response on the second read
        clear_logs();
        err_rd_idx = 1;
        run_job(32'h0000_1000, 32'h0000_2000, 16'd3, lat, b1, dn, bd, ed, dnx);
        err_rd_idx = -1;
        check_eq("t3_done", 32'(dn), 32'h1);
        check_eq("t3_latency", 32'(lat), 32'd9);
        check_eq("t3_err", 32'(ed), 32'h1);
        check_eq("t3_nrd", 32'(rd_a.size()), 32'd1);
        check_eq("t3_nwr", 32'(wr_a.size()), 32'd1);
        check_eq("t3_wa0", wr_a[0], 32'h0000_2000);
        check_eq("t3_nonseq_cycles", 32'(nonseq_cnt), 32'd3);
        check_eq("t3_err_sticky", 32'(ERR), 32'h1);

        // 4: zero-length job (also clears the sticky error)
        clear_logs();
        run_job(32'h0000_1000, 32'h0000_2000, 16'd0, lat, b1, dn, bd, ed, dnx);
        check_eq("t4_done", 32'(dn), 32'h1);
        check_eq("t4_latency", 32'(lat), 32'd2);
        check_eq("t4_busy_c1", 32'(b1), 32'h1);
        check_eq("t4_err_cleared", 32'(ed), 32'h0);
        check_eq("t4_nonseq_cycles", 32'(nonseq_cnt), 32'd0);

        // 5: address wrap and unaligned destination
        clear_logs();
        run_job(32'hFFFF_FFFC, 32'h0000_0013, 16'd2, lat, b1, dn, bd, ed, dnx);
        check_eq("t5_latency", 32'(lat), 32'd10);
        check_eq("t5_rd0", rd_a[0], 32'hFFFF_FFFC);
        check_eq("t5_rd1", rd_a[1], 32'h0000_0000);
        check_eq("t5_wa0", wr_a[0], 32'h0000_0010);
        check_eq("t5_wa1", wr_a[1], 32'h0000_0014);
        check_eq("t5_wd0", wr_d[0], 32'h2152_4113);
        check_eq("t5_wd1", wr_d[1], 32'hDEAD_BEEF);

        // 6: START while busy is ignored; reset in the write data phase aborts
        clear_logs();
        done_before = done_cnt;
        @(negedge HCLK);
        START    = 1'b1;
        SRC_ADDR = 32'h0000_1000;
        DST_ADDR = 32'h0000_3000;
        LEN      = 16'd3;
        @(negedge HCLK);
        START = 1'b0;
        @(negedge HCLK);
        START    = 1'b1;
        SRC_ADDR = 32'h0000_5000;
        DST_ADDR = 32'h0000_6000;
        LEN      = 16'd1;
        @(negedge HCLK);
        START = 1'b0;
        check_eq("t6_wr_addr_kept", HADDR, 32'h0000_3000);
        check_eq("t6_wr_phase", {30'd0, HTRANS[1], HWRITE}, 32'h3);
        @(negedge HCLK);
        check_eq("t6_in_wr_data", HWDATA, 32'hDEAD_AEEF);
        #1;
        HRESETn = 1'b0;
        #1;
        check_eq("t6_rst_htrans", 32'(HTRANS), 32'h0);
        check_eq("t6_rst_haddr", HADDR, 32'h0);
        check_eq("t6_rst_hwdata", HWDATA, 32'h0);
        check_eq("t6_rst_flags", {29'd0, BUSY, DONE, ERR, HWRITE}, 32'h0);
        repeat (2) @(negedge HCLK);
        HRESETn = 1'b1;
        repeat (20) @(negedge HCLK);
        check_eq("t6_no_done", 32'(done_cnt - done_before), 32'd0);
        check_eq("t6_nrd", 32'(rd_a.size()), 32'd1);
        check_eq("t6_idle_after", {29'd0, BUSY, HTRANS}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
